// File: rtl/harris_response_seq_if.sv
// harris_response_seq_if: operand/result valid-ready bus for the Harris response stage
// HARRIS_THRESH_EN adds thresh/corner to the bus
interface harris_response_seq_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 2*WIDTH+4
);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [WIDTH-1:0] sxx, syy, sxy;
  logic signed [OUT_W-1:0] r;
`ifdef HARRIS_THRESH_EN
  logic signed [OUT_W-1:0] thresh;
  logic corner;
`endif
  modport master (
    output in_valid, sxx, syy, sxy, out_ready,
`ifdef HARRIS_THRESH_EN
    output thresh, input corner,
`endif
    input in_ready, out_valid, r, busy
  );
  modport slave (
    input in_valid, sxx, syy, sxy, out_ready,
`ifdef HARRIS_THRESH_EN
    input thresh, output corner,
`endif
    output in_ready, out_valid, r, busy
  );
endinterface

// File: rtl/harris_response_seq.sv
// harris_response_seq: R = (Sxx*Syy - Sxy^2) - k*(Sxx+Syy)^2 on one reused shift-add multiplier
// HARRIS_THRESH_EN adds a registered strict signed compare corner = (r > thresh)
module harris_response_seq #(
  parameter int WIDTH   = 16,
  parameter int K_W     = 8,
  parameter int K_NUM   = 5,
  parameter int K_SHIFT = 7,
  parameter int OUT_W   = 2*WIDTH+4
) (
  input logic clk,
  input logic resetn,
  harris_response_seq_if.slave bus
);
  localparam int AW = 2*WIDTH+2+K_W;
  localparam int MW = (WIDTH+1 > K_W) ? WIDTH+1 : K_W;
  localparam int CW = $clog2(MW+1);
  typedef enum logic [2:0] {IDLE, MDET1, MDET2, MTR, MK, FIN, DONE} state_t;
  state_t state;
  logic signed [WIDTH-1:0] a, b, c;
  logic sg, last;
  logic [AW-1:0] mcand, acc, acc_nx;
  logic [MW-1:0] mplier;
  logic [CW-1:0] cnt;
  logic signed [2*WIDTH:0] det, prod;
  logic [WIDTH:0] tr, tr_mag;
  logic [WIDTH-1:0] ma, mb, mc;
  logic signed [OUT_W-1:0] r_nx;
  always_comb begin
    acc_nx = acc + (mplier[0] ? mcand : '0);
    prod = $signed({1'b0, acc_nx[2*WIDTH-1:0]});
    ma = bus.sxx[WIDTH-1] ? -bus.sxx : bus.sxx;
    mb = bus.syy[WIDTH-1] ? -bus.syy : bus.syy;
    mc = c[WIDTH-1] ? -c : c;
    tr = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    tr_mag = tr[WIDTH] ? -tr : tr;
    r_nx = OUT_W'(det) - OUT_W'(acc >> K_SHIFT);
    last = cnt == (state == MTR ? CW'(WIDTH) : state == MK ? CW'(K_W-1) : CW'(WIDTH-1));
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.r <= '0;
      a <= '0;
      b <= '0;
      c <= '0;
      sg <= 1'b0;
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
      cnt <= '0;
      det <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a <= bus.sxx;
          b <= bus.syy;
          c <= bus.sxy;
          sg <= bus.sxx[WIDTH-1] ^ bus.syy[WIDTH-1];
          mcand <= AW'(ma);
          mplier <= MW'(mb);
          acc <= '0;
          cnt <= '0;
          bus.in_ready <= 1'b0;
          bus.busy <= 1'b1;
          state <= MDET1;
        end
        MDET1, MDET2, MTR, MK: begin
          acc <= acc_nx;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt + CW'(1);
          if (last) begin
            acc <= '0;
            cnt <= '0;
            case (state)
              MDET1: begin
                det <= sg ? -prod : prod;
                mcand <= AW'(mc);
                mplier <= MW'(mc);
                state <= MDET2;
              end
              MDET2: begin
                det <= det - prod;
                mcand <= AW'(tr_mag);
                mplier <= MW'(tr_mag);
                state <= MTR;
              end
              MTR: begin
                mcand <= acc_nx;
                mplier <= MW'(K_NUM);
                state <= MK;
              end
              default: begin
                acc <= acc_nx;
                state <= FIN;
              end
            endcase
          end
        end
        FIN: begin
          bus.r <= r_nx;
          bus.out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef HARRIS_THRESH_EN
  logic signed [OUT_W-1:0] thr;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      thr <= '0;
      bus.corner <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) thr <= bus.thresh;
      if (state == FIN) bus.corner <= r_nx > thr;
    end
  end
`endif
endmodule
